// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: priority-arbitrated tune player driving the tone generator.
// Define BUZZ_NOTE_GAP_EN to insert a GAP_CLKS silent gap after each non-last note.
module buzzer_sequencer #(
   parameter int TICK_DIV = 2_500_000,
   parameter int GAP_CLKS = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic        mute,
   output logic [19:0] pwm_parameter,
   output logic        tone_en,
   output logic        busy,
   output logic [1:0]  active_id,
   output logic        done
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int GW = $clog2(GAP_CLKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

   localparam logic [3:0] P_REST = 4'd0;
   localparam logic [3:0] P_C5 = 4'd1;
   localparam logic [3:0] P_D5 = 4'd2;
   localparam logic [3:0] P_E5 = 4'd3;
   localparam logic [3:0] P_F5 = 4'd4;
   localparam logic [3:0] P_G5 = 4'd5;
   localparam logic [3:0] P_A5 = 4'd6;
   localparam logic [3:0] P_B5 = 4'd7;
   localparam logic [3:0] P_C6 = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

`ifdef BUZZ_NOTE_GAP_EN
   localparam state_t S_NOTE_END = S_GAP;
`else
   localparam state_t S_NOTE_END = S_LOAD;
`endif

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    pending;
   logic [3:0]    pend_nxt;
   logic [3:0]    drop;
   logic [3:0]    clr;
   logic [1:0]    id_q;
   logic [1:0]    hi_idx;
   logic          any_pend;
   logic          preempt;
   logic          start;
   logic          expire;
   logic          gap_exp;
   logic [3:0]    addr;
   logic          last_q;
   logic [TW-1:0] tick_cnt;
   logic [3:0]    unit_cnt;
   logic [GW-1:0] gap_cnt;
   logic [19:0]   pwm_q;
   logic          tone_q;
   logic [8:0]    rom_w;
   logic [19:0]   rom_per;

   function automatic logic [8:0] ent(
      input logic       last,
      input logic [3:0] p,
      input logic [3:0] d
   );
      return {last, p, d};
   endfunction

   // Entry = {last, pitch, dur}; unused slots read as a terminating rest.
   function automatic logic [8:0] rom_word(
      input logic [1:0] t,
      input logic [3:0] a
   );
      logic [8:0] w;
      w = ent(1'b1, P_REST, 4'd1);
      case ({t, a})
         6'h00: w = ent(1'b0, P_E5, 4'd1);
         6'h01: w = ent(1'b1, P_C5, 4'd1);
         6'h10: w = ent(1'b0, P_C5, 4'd1);
         6'h11: w = ent(1'b0, P_E5, 4'd1);
         6'h12: w = ent(1'b0, P_G5, 4'd1);
         6'h13: w = ent(1'b1, P_C6, 4'd2);
         6'h20: w = ent(1'b0, P_C6, 4'd1);
         6'h21: w = ent(1'b0, P_REST, 4'd1);
         6'h22: w = ent(1'b1, P_C6, 4'd1);
         6'h30: w = ent(1'b0, P_B5, 4'd2);
         6'h31: w = ent(1'b0, P_A5, 4'd2);
         6'h32: w = ent(1'b0, P_G5, 4'd2);
         6'h33: w = ent(1'b0, P_F5, 4'd2);
         6'h34: w = ent(1'b0, P_E5, 4'd2);
         6'h35: w = ent(1'b0, P_D5, 4'd2);
         6'h36: w = ent(1'b1, P_C5, 4'd4);
         default: w = ent(1'b1, P_REST, 4'd1);
      endcase
      return w;
   endfunction

   // Zero doubles as the rest marker for tone_en.
   function automatic logic [19:0] period(input logic [3:0] p);
      logic [19:0] v;
      case (p)
         P_C5: v = 20'd95556;
         P_D5: v = 20'd85131;
         P_E5: v = 20'd75841;
         P_F5: v = 20'd71585;
         P_G5: v = 20'd63775;
         P_A5: v = 20'd56817;
         P_B5: v = 20'd50618;
         P_C6: v = 20'd47777;
         default: v = 20'd0;
      endcase
      return v;
   endfunction

   always_comb begin
      hi_idx = 2'd0;
      priority case (1'b1)
         pending[3]: hi_idx = 2'd3;
         pending[2]: hi_idx = 2'd2;
         pending[1]: hi_idx = 2'd1;
         default:    hi_idx = 2'd0;
      endcase
   end

   assign any_pend = |pending;
   assign preempt  = any_pend && (hi_idx > id_q);
   assign expire   = (tick_cnt == TICK_LAST) && (unit_cnt == 4'd0);
   assign gap_exp  = (gap_cnt == GAP_LAST);
   assign rom_w    = rom_word(id_q, addr);
   assign rom_per  = period(rom_w[7:4]);

   always_comb begin
      drop     = busy ? (4'b0001 << id_q) : 4'b0000;
      clr      = start ? (4'b0001 << hi_idx) : 4'b0000;
      pend_nxt = (pending | (req & ~drop)) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (any_pend) begin
               state_nxt = S_LOAD;
               start     = 1'b1;
            end
         end
         S_LOAD: begin
            if (preempt) begin
               start = 1'b1;
            end else begin
               state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            if (preempt) begin
               state_nxt = S_LOAD;
               start     = 1'b1;
            end else if (expire) begin
               state_nxt = last_q ? S_DONE : S_NOTE_END;
            end
         end
         S_GAP: begin
            if (preempt) begin
               state_nxt = S_LOAD;
               start     = 1'b1;
            end else if (gap_exp) begin
               state_nxt = S_LOAD;
            end
         end
         S_DONE: begin
            if (any_pend) begin
               state_nxt = S_LOAD;
               start     = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= '0;
         id_q     <= '0;
         addr     <= '0;
         last_q   <= 1'b0;
         tick_cnt <= '0;
         unit_cnt <= '0;
         gap_cnt  <= '0;
         pwm_q    <= '0;
         tone_q   <= 1'b0;
      end else begin
         pending <= pend_nxt;
         if (start) begin
            id_q <= hi_idx;
            addr <= '0;
         end else if (state == S_PLAY && expire && !last_q) begin
            addr <= addr + 4'd1;
         end
         // dur 0 wraps to 15 here, giving 16 units.
         if (state == S_LOAD && state_nxt == S_PLAY) begin
            last_q   <= rom_w[8];
            pwm_q    <= rom_per;
            tone_q   <= (rom_per != 20'd0);
            tick_cnt <= '0;
            unit_cnt <= rom_w[3:0] - 4'd1;
         end else begin
            if (state == S_PLAY) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  unit_cnt <= unit_cnt - 4'd1;
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
            if (state_nxt inside {S_IDLE, S_GAP, S_DONE}) begin
               tone_q <= 1'b0;
            end
         end
         gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      end
   end

   always_comb begin
      busy          = 1'b1;
      done          = 1'b0;
      tone_en       = 1'b0;
      pwm_parameter = pwm_q;
      active_id     = id_q;
      unique case (state)
         S_IDLE:         busy = 1'b0;
         S_LOAD, S_PLAY: tone_en = tone_q & ~mute;
         S_GAP:          tone_en = 1'b0;
         S_DONE:         done = 1'b1;
         default:        busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb_buzzer_sequencer: directed stimulus, tune-timeline model, per-cycle compare.
// Literal checks pin the timeline model at hand-computed edges.
module tb_buzzer_sequencer;

   localparam int TICK = 10;
   localparam int GAPN = 4;
`ifdef BUZZ_NOTE_GAP_EN
   localparam int GAPC = GAPN;
`else
   localparam int GAPC = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = 4'b0;
   logic        mute = 1'b0;
   logic [19:0] pwm_parameter;
   logic        tone_en;
   logic        busy;
   logic [1:0]  active_id;
   logic        done;

   always #5 clk = ~clk;

   buzzer_sequencer #(
      .TICK_DIV(TICK),
      .GAP_CLKS(GAPN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .mute(mute),
      .pwm_parameter(pwm_parameter),
      .tone_en(tone_en),
      .busy(busy),
      .active_id(active_id),
      .done(done)
   );

   typedef struct packed {
      logic [19:0] pwm;
      logic        pv;
      logic        tone;
      logic        busy;
      logic [1:0]  id;
      logic        done;
   } frame_t;

   // Tunes as (period word, units); period 0 is a rest.
   int t_pwm [4][7] = '{
      '{75841, 95556, 0, 0, 0, 0, 0},
      '{95556, 75841, 63775, 47777, 0, 0, 0},
      '{47777, 0, 47777, 0, 0, 0, 0},
      '{50618, 56817, 63775, 71585, 75841, 85131, 95556}
   };
   int t_dur [4][7] = '{
      '{1, 1, 0, 0, 0, 0, 0},
      '{1, 1, 1, 2, 0, 0, 0},
      '{1, 1, 1, 0, 0, 0, 0},
      '{2, 2, 2, 2, 2, 2, 4}
   };
   int t_len [4] = '{2, 4, 3, 7};

   frame_t     cur = '{pwm: 20'd0, pv: 1'b1, tone: 1'b0,
                       busy: 1'b0, id: 2'd0, done: 1'b0};
   frame_t     mq[$];
   logic [3:0] mp = 4'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string nm, input logic [19:0] act,
                      input logic [19:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Expand a whole tune into its per-cycle output frames.
   task automatic build(input int t, input frame_t prev);
      logic [19:0] pp;
      logic        ppv;
      logic        pt;
      logic [1:0]  id;
      int          v;
      pp  = prev.pwm;
      ppv = prev.pv;
      pt  = prev.tone;
      id  = t[1:0];
      mq.delete();
      for (int i = 0; i < t_len[t]; i++) begin
         mq.push_back('{pwm: pp, pv: ppv, tone: pt, busy: 1'b1,
                        id: id, done: 1'b0});
         v   = t_pwm[t][i];
         pp  = v[19:0];
         ppv = (v != 0);
         pt  = (v != 0);
         repeat (t_dur[t][i] * TICK)
            mq.push_back('{pwm: pp, pv: ppv, tone: pt, busy: 1'b1,
                           id: id, done: 1'b0});
         if (GAPC > 0 && i != t_len[t] - 1) begin
            pt = 1'b0;
            repeat (GAPC)
               mq.push_back('{pwm: pp, pv: ppv, tone: 1'b0, busy: 1'b1,
                              id: id, done: 1'b0});
         end
      end
      mq.push_back('{pwm: pp, pv: ppv, tone: 1'b0, busy: 1'b1,
                     id: id, done: 1'b1});
   endtask

   always @(posedge clk) begin : model
      logic [1:0] hi;
      logic [3:0] drop;
      logic [3:0] np;
      logic       st;
      if (!rst_n) begin
         mq.delete();
         mp  = 4'b0;
         cur = '{pwm: 20'd0, pv: 1'b1, tone: 1'b0,
                 busy: 1'b0, id: 2'd0, done: 1'b0};
      end else begin
         hi = mp[3] ? 2'd3 : mp[2] ? 2'd2 : mp[1] ? 2'd1 : 2'd0;
         if (cur.busy && !cur.done)
            st = (mp != 4'b0) && (hi > cur.id);
         else
            st = (mp != 4'b0);
         drop = cur.busy ? (4'b0001 << cur.id) : 4'b0;
         np   = mp | (req & ~drop);
         if (st) begin
            build(int'(hi), cur);
            np = np & ~(4'b0001 << hi);
         end
         mp = np;
         if (mq.size() > 0)
            cur = mq.pop_front();
         else
            cur = '{pwm: cur.pwm, pv: cur.pv, tone: 1'b0,
                    busy: 1'b0, id: cur.id, done: 1'b0};
      end
   end

   always @(negedge clk) begin
      chk("tone_en", {19'b0, tone_en}, {19'b0, cur.tone & ~mute});
      chk("busy", {19'b0, busy}, {19'b0, cur.busy});
      chk("done", {19'b0, done}, {19'b0, cur.done});
      if (cur.busy)
         chk("active_id", {18'b0, active_id}, {18'b0, cur.id});
      if (cur.pv)
         chk("pwm_parameter", pwm_parameter, cur.pwm);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycn(input int n);
      repeat (n) cyc();
   endtask

   task automatic pulse(input logic [3:0] r);
      req = r;
      cyc();
      req = 4'b0;
   endtask

   task automatic wait_idle(input int bound, output int nd,
                            output logic [1:0] id0);
      int   k;
      logic to;
      nd  = 0;
      id0 = 2'd0;
      k   = 0;
      to  = 1'b1;
      while (k < bound) begin
         cyc();
         k++;
         if (done) begin
            if (nd == 0) id0 = active_id;
            nd++;
         end
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      chk("idle_timeout", {19'b0, to}, 20'd0);
   endtask

   int         nd;
   logic [1:0] id0;
   logic [1:0] id_done2;

   initial begin
      cycn(3);
      chk("rst_pwm", pwm_parameter, 20'd0);
      chk("rst_busy", {19'b0, busy}, 20'd0);
      chk("rst_tone", {19'b0, tone_en}, 20'd0);
      rst_n = 1'b1;
      cyc();

      // T0 alone
      pulse(4'b0001);
      cyc();
      chk("t0_load_busy", {19'b0, busy}, 20'd1);
      chk("t0_load_tone", {19'b0, tone_en}, 20'd0);
      cyc();
      chk("t0_e5_tone", {19'b0, tone_en}, 20'd1);
      chk("t0_e5_pwm", pwm_parameter, 20'd75841);
      cycn(10);
      chk("t0_hold_pwm", pwm_parameter, 20'd75841);
      chk("t0_hold_tone", {19'b0, tone_en}, (GAPC == 0) ? 20'd1 : 20'd0);
      cycn(1 + GAPC);
      chk("t0_c5_pwm", pwm_parameter, 20'd95556);
      cycn(10);
      chk("t0_done", {19'b0, done}, 20'd1);
      chk("t0_done_tone", {19'b0, tone_en}, 20'd0);
      cyc();
      chk("t0_idle_busy", {19'b0, busy}, 20'd0);
      chk("t0_idle_pwm", pwm_parameter, 20'd95556);
      cycn(3);

      // T1 and T0 together: T1 first, T0 from pending
      pulse(4'b0011);
      cycn(2);
      chk("t1_first_pwm", pwm_parameter, 20'd95556);
      chk("t1_first_id", {18'b0, active_id}, 20'd1);
      nd = 0;
      id0 = 2'd0;
      id_done2 = 2'd3;
      for (int k = 0; k < 400 && busy; k++) begin
         cyc();
         if (done) begin
            if (nd == 0) id0 = active_id;
            else id_done2 = active_id;
            nd++;
         end
      end
      chk("t1t0_idle", {19'b0, busy}, 20'd0);
      chk("t1t0_ndone", nd[19:0], 20'd2);
      chk("t1t0_id0", {18'b0, id0}, 20'd1);
      chk("t1t0_id1", {18'b0, id_done2}, 20'd0);
      cycn(3);

      // T3 preempts T0; repeat T0 request is dropped
      pulse(4'b0001);
      cycn(5);
      pulse(4'b1001);
      cyc();
      chk("pre_load_pwm", pwm_parameter, 20'd75841);
      chk("pre_load_id", {18'b0, active_id}, 20'd3);
      cyc();
      chk("pre_b5_pwm", pwm_parameter, 20'd50618);
      chk("pre_b5_tone", {19'b0, tone_en}, 20'd1);
      wait_idle(400, nd, id0);
      chk("pre_ndone", nd[19:0], 20'd1);
      chk("pre_done_id", {18'b0, id0}, 20'd3);
      cycn(6);
      chk("pre_no_replay", {19'b0, busy}, 20'd0);

      // T2 with rest and mute
      pulse(4'b0100);
      cycn(2);
      chk("t2_c6_pwm", pwm_parameter, 20'd47777);
      cycn(15 + GAPC);
      chk("t2_rest_tone", {19'b0, tone_en}, 20'd0);
      chk("t2_rest_busy", {19'b0, busy}, 20'd1);
      cycn(9 + GAPC);
      mute = 1'b1;
      cyc();
      chk("t2_mute_tone", {19'b0, tone_en}, 20'd0);
      chk("t2_mute_pwm", pwm_parameter, 20'd47777);
      cycn(2);
      mute = 1'b0;
      cyc();
      chk("t2_unmute_tone", {19'b0, tone_en}, 20'd1);
      cycn(4);
      chk("t2_done", {19'b0, done}, 20'd1);
      cyc();
      chk("t2_idle", {19'b0, busy}, 20'd0);
      cycn(3);

      // reset mid T3 with T0 pending, then T1 from entry 0
      pulse(4'b1001);
      cycn(40);
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_pwm", pwm_parameter, 20'd0);
      chk("mid_rst_tone", {19'b0, tone_en}, 20'd0);
      chk("mid_rst_busy", {19'b0, busy}, 20'd0);
      chk("mid_rst_id", {18'b0, active_id}, 20'd0);
      rst_n = 1'b1;
      cycn(6);
      chk("rst_pend_clr", {19'b0, busy}, 20'd0);
      pulse(4'b0010);
      cycn(2);
      chk("rst_t1_pwm", pwm_parameter, 20'd95556);
      chk("rst_t1_id", {18'b0, active_id}, 20'd1);
      cycn(10);
      chk("rst_t1_hold", pwm_parameter, 20'd95556);
      cycn(1 + GAPC);
      chk("rst_t1_e5", pwm_parameter, 20'd75841);
      wait_idle(300, nd, id0);
      chk("rst_t1_ndone", nd[19:0], 20'd1);
      chk("rst_t1_did", {18'b0, id0}, 20'd1);
      cycn(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
